captura_pixel_camera: RTL and testbench
=======================================

Name: captura_pixel_camera

Overview:
- Upstream capture stage for the camera path, running in the 50 MHz system clock domain.
- Samples the camera's asynchronous PCLK/VSYNC/HREF/D bus and frames one image on request.
- Emits one byte per PCLK rising edge, with a one-cycle enable strobe that drives the 16-bit pixel register's D/enable inputs.
- Signals pixel completion every second byte and tracks pixel column/row coordinates for downstream colour sampling.

Parameters:
- H_PIXELS, 640, pixels per line (2 bytes each).
- V_LINES, 480, lines per frame.
- SYNC_STAGES, 2, flip-flop stages on cam_pclk/cam_vsync/cam_href (minimum 2).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- iniciar  in  1  one-cycle request to capture the next full frame.
- cam_pclk  in  1  camera pixel clock, asynchronous, at most clock/4.
- cam_vsync  in  1  camera frame sync, high during vertical blanking.
- cam_href  in  1  camera line valid.
- cam_d  in  8  camera data bus.
- byte_D  out  8  captured byte; feeds pixel register D.
- byte_enable  out  1  one-cycle strobe; feeds pixel register enable.
- pixel_pronto  out  1  one-cycle pulse: pixel register now holds a complete pixel.
- x  out  10  column of the current/last completed pixel.
- y  out  9  current line.
- ocupado  out  1  high from accepted iniciar until frame end.
- frame_pronto  out  1  one-cycle pulse at frame end.
- erro_linha  out  1  sticky: some line had a pixel count other than H_PIXELS; cleared on accepted iniciar.

Behaviour:
- Reset: all outputs 0, FSM in OCIOSO, synchronizers cleared, byte phase 0.
- Synchronization: cam_pclk, cam_vsync, cam_href pass through SYNC_STAGES flops.
  - cam_d is sampled through SYNC_STAGES+1 flops so it aligns with the detected PCLK edge.
  - Edge detectors produce pclk_sobe, vsync_sobe, vsync_desce and href_desce.
- FSM states:
  - OCIOSO: iniciar -> ESPERA_VSYNC; clear x, y, phase and erro_linha; set ocupado. iniciar in any other state is ignored.
  - ESPERA_VSYNC: wait for vsync_desce (start of active frame) -> ESPERA_HREF. A frame already in progress is never captured partially.
  - ESPERA_HREF: synced href high -> CAPTURA. vsync_sobe here means premature frame end -> FIM.
  - CAPTURA: on each pclk_sobe with href high:
    - byte_D <= synced cam_d; byte_enable pulses 1 cycle; phase toggles.
    - On phase 1->0, pixel_pronto pulses in the cycle after byte_enable, so the downstream register has already loaded.
    - x increments on that same cycle, except the first pixel of a line, which leaves x at 0.
  - CAPTURA on href_desce:
    - If phase=1 (odd byte count) or pixels in line != H_PIXELS, set erro_linha.
    - Then phase=0, x=0, y++.
    - If y reaches V_LINES -> FIM, else -> ESPERA_HREF.
  - FIM: frame_pronto pulses 1 cycle, ocupado=0 -> OCIOSO.
- Boundaries:
  - pclk_sobe and href_desce in the same cycle: the byte is captured first, then the line closes.
  - vsync_sobe in CAPTURA: the frame is aborted to FIM with erro_linha set.
  - x saturates at H_PIXELS-1; extra pixels set erro_linha and are still strobed.
  - Lines beyond V_LINES never occur, because FIM is entered first.
- Reset mid-frame: immediate return to reset state; no pulses are emitted.

Optional Feature:
- Macro: CAPTURA_DECIMACAO_EN.
- Defined: keep only even x and even y.
  - byte_enable and pixel_pronto are suppressed for discarded pixels.
  - x/y report decimated coordinates (0..H_PIXELS/2-1, 0..V_LINES/2-1).
  - The line-length check still uses the full H_PIXELS.
- Undefined: every pixel is delivered.

Decomposition:
- Package captura_pkg: FSM state encoding (OCIOSO, ESPERA_VSYNC, ESPERA_HREF, CAPTURA, FIM), X_WIDTH=10, Y_WIDTH=9, BYTE_WIDTH=8.
- Sub-module sincronizador_borda: parameterized SYNC_STAGES synchronizer with rise/fall pulse outputs; instantiated three times.

Test Plan:
- Reset: reset_n=0 mid-capture -> all outputs 0 immediately; after release, iniciar restarts cleanly.
- Single frame (H_PIXELS=4, V_LINES=2, pclk=clock/4), bytes 0xAA,0xCC per pixel:
  - byte_enable 16 pulses, pixel_pronto 8 pulses, x 0..3 per line, y 0..1.
  - frame_pronto once; erro_linha=0.
- Mid-frame iniciar: request while vsync low with href active -> no bytes until the next vsync fall.
- Short line (3 pixels) -> erro_linha=1 after href fall; cleared by the next iniciar.
- Premature vsync rise after line 0 -> frame_pronto pulse, erro_linha=1, ocupado=0.
- CAPTURA_DECIMACAO_EN with 4x2 -> 2 pixel_pronto pulses (x=0,1, y=0); byte_enable 4 pulses.

Source files
------------

// File: rtl/captura_pkg.sv
// Shared widths and FSM encoding for the camera pixel capture stage.
package captura_pkg;

    localparam int unsigned X_WIDTH    = 10;
    localparam int unsigned Y_WIDTH    = 9;
    localparam int unsigned BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA_VSYNC,
        ESPERA_HREF,
        CAPTURA,
        FIM
    } estado_t;

endpackage

// File: rtl/sincronizador_borda.sv
// Multi-flop synchronizer for one asynchronous camera line, with rise/fall pulses
// aligned to the synchronized level.
module sincronizador_borda #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic sobe_c,
    output logic desce_c
);

    logic [STAGES-1:0] cadeia;
    logic              q_ant;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cadeia <= '0;
            q_ant  <= 1'b0;
        end else begin
            cadeia <= {cadeia[STAGES-2:0], d};
            q_ant  <= cadeia[STAGES-1];
        end
    end

    assign q       = cadeia[STAGES-1];
    assign sobe_c  = cadeia[STAGES-1] & ~q_ant;
    assign desce_c = ~cadeia[STAGES-1] & q_ant;

endmodule

// File: rtl/captura_pixel_camera.sv
// Camera capture front end: synchronizes PCLK/VSYNC/HREF/D, frames one image per
// request and strobes bytes/pixels with coordinates. Optional CAPTURA_DECIMACAO_EN
// keeps only even columns and even lines.
module captura_pixel_camera
    import captura_pkg::*;
#(
    parameter int unsigned H_PIXELS    = 640,
    parameter int unsigned V_LINES     = 480,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  iniciar,
    input  logic                  cam_pclk,
    input  logic                  cam_vsync,
    input  logic                  cam_href,
    input  logic [BYTE_WIDTH-1:0] cam_d,
    output logic [BYTE_WIDTH-1:0] byte_D,
    output logic                  byte_enable,
    output logic                  pixel_pronto,
    output logic [X_WIDTH-1:0]    x,
    output logic [Y_WIDTH-1:0]    y,
    output logic                  ocupado,
    output logic                  frame_pronto,
    output logic                  erro_linha
);

    localparam int unsigned          CNT_WIDTH = X_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_H     = CNT_WIDTH'(H_PIXELS);
    localparam logic [CNT_WIDTH-1:0] CNT_ULT   = CNT_WIDTH'(H_PIXELS - 1);
    localparam logic [Y_WIDTH:0]     Y_FIM     = (Y_WIDTH + 1)'(V_LINES);

    logic pclk_sobe, vsync_sobe, vsync_desce, href_q, href_desce;
    logic unused_pclk_q, unused_pclk_desce, unused_vsync_q, unused_href_sobe;

    sincronizador_borda #(.STAGES(SYNC_STAGES)) u_sinc_pclk (
        .clock(clock), .reset_n(reset_n), .d(cam_pclk),
        .q(unused_pclk_q), .sobe_c(pclk_sobe), .desce_c(unused_pclk_desce)
    );
    sincronizador_borda #(.STAGES(SYNC_STAGES)) u_sinc_vsync (
        .clock(clock), .reset_n(reset_n), .d(cam_vsync),
        .q(unused_vsync_q), .sobe_c(vsync_sobe), .desce_c(vsync_desce)
    );
    sincronizador_borda #(.STAGES(SYNC_STAGES)) u_sinc_href (
        .clock(clock), .reset_n(reset_n), .d(cam_href),
        .q(href_q), .sobe_c(unused_href_sobe), .desce_c(href_desce)
    );

    // Data takes one extra stage so it lines up with the detected PCLK rise.
    logic [BYTE_WIDTH-1:0] d_pipe [SYNC_STAGES+1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= SYNC_STAGES; i++) d_pipe[i] <= '0;
        end else begin
            d_pipe[0] <= cam_d;
            for (int i = 1; i <= SYNC_STAGES; i++) d_pipe[i] <= d_pipe[i-1];
        end
    end

    estado_t               estado, estado_n;
    logic [Y_WIDTH-1:0]    y_linha, yl_n;
    logic [CNT_WIDTH-1:0]  cnt, cnt_n;
    logic [X_WIDTH-1:0]    px, px_n, x_n, coluna_c;
    logic                  fase, fase_n, pend, pend_n, manter_c;
    logic [BYTE_WIDTH-1:0] byte_d_n;
    logic                  byte_en_n, pronto_n, ocupado_n, frame_n, erro_n;
    logic [CNT_WIDTH-1:0]  cnt_sat_c;
    logic [Y_WIDTH:0]      y_prox_c;

    assign cnt_sat_c = (cnt > CNT_ULT) ? CNT_ULT : cnt;
    assign y_prox_c  = {1'b0, y_linha} + (Y_WIDTH + 1)'(1);

`ifdef CAPTURA_DECIMACAO_EN
    assign manter_c = ~cnt[0] & ~y_linha[0];
    assign coluna_c = X_WIDTH'(cnt_sat_c >> 1);
    assign y        = y_linha >> 1;
`else
    assign manter_c = 1'b1;
    assign coluna_c = X_WIDTH'(cnt_sat_c);
    assign y        = y_linha;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado       <= OCIOSO;
            y_linha      <= '0;
            cnt          <= '0;
            px           <= '0;
            fase         <= 1'b0;
            pend         <= 1'b0;
            byte_D       <= '0;
            byte_enable  <= 1'b0;
            pixel_pronto <= 1'b0;
            x            <= '0;
            ocupado      <= 1'b0;
            frame_pronto <= 1'b0;
            erro_linha   <= 1'b0;
        end else begin
            estado       <= estado_n;
            y_linha      <= yl_n;
            cnt          <= cnt_n;
            px           <= px_n;
            fase         <= fase_n;
            pend         <= pend_n;
            byte_D       <= byte_d_n;
            byte_enable  <= byte_en_n;
            pixel_pronto <= pronto_n;
            x            <= x_n;
            ocupado      <= ocupado_n;
            frame_pronto <= frame_n;
            erro_linha   <= erro_n;
        end
    end

    always_comb begin
        estado_n  = estado;
        yl_n      = y_linha;
        cnt_n     = cnt;
        px_n      = px;
        fase_n    = fase;
        pend_n    = 1'b0;
        byte_d_n  = byte_D;
        byte_en_n = 1'b0;
        pronto_n  = 1'b0;
        x_n       = x;
        ocupado_n = ocupado;
        frame_n   = 1'b0;
        erro_n    = erro_linha;

        unique case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    estado_n  = ESPERA_VSYNC;
                    x_n       = '0;
                    yl_n      = '0;
                    cnt_n     = '0;
                    fase_n    = 1'b0;
                    erro_n    = 1'b0;
                    ocupado_n = 1'b1;
                end
            end
            ESPERA_VSYNC: begin
                if (vsync_desce) estado_n = ESPERA_HREF;
            end
            ESPERA_HREF: begin
                if (vsync_sobe) begin
                    estado_n = FIM;
                    erro_n   = 1'b1;
                end else if (href_q) begin
                    estado_n = CAPTURA;
                end
            end
            CAPTURA: begin
                if (vsync_sobe) begin
                    estado_n = FIM;
                    erro_n   = 1'b1;
                end else begin
                    // A byte coinciding with the HREF fall still belongs to this line.
                    if (pclk_sobe && (href_q || href_desce)) begin
                        if (manter_c) begin
                            byte_d_n  = d_pipe[SYNC_STAGES];
                            byte_en_n = 1'b1;
                        end
                        fase_n = ~fase;
                        if (fase) begin
                            pend_n = manter_c;
                            px_n   = coluna_c;
                            if (cnt >= CNT_H) erro_n = 1'b1;
                            if (cnt != '1) cnt_n = cnt + CNT_WIDTH'(1);
                        end
                    end
                    if (href_desce) begin
                        if (fase_n || (cnt_n != CNT_H)) erro_n = 1'b1;
                        fase_n   = 1'b0;
                        x_n      = '0;
                        cnt_n    = '0;
                        yl_n     = y_prox_c[Y_WIDTH-1:0];
                        estado_n = (y_prox_c == Y_FIM) ? FIM : ESPERA_HREF;
                    end
                end
            end
            FIM: begin
                frame_n   = 1'b1;
                ocupado_n = 1'b0;
                estado_n  = OCIOSO;
            end
            default: estado_n = OCIOSO;
        endcase

        // Pixel completion is announced one cycle after its second byte was strobed.
        if (pend) begin
            pronto_n = 1'b1;
            x_n      = px;
        end
    end

endmodule

// File: tb/tb_captura_pixel_camera.sv
// Scoreboard bench for captura_pixel_camera with a 4x2 frame and PCLK at clock/4.
module tb_captura_pixel_camera;

    localparam int H = 4;
    localparam int V = 2;
`ifdef CAPTURA_DECIMACAO_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n, iniciar, cam_pclk, cam_vsync, cam_href;
    logic [7:0] cam_d, byte_D;
    logic       byte_enable, pixel_pronto, ocupado, frame_pronto, erro_linha;
    logic [9:0] x;
    logic [8:0] y;

    captura_pixel_camera #(.H_PIXELS(H), .V_LINES(V), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset_n(reset_n), .iniciar(iniciar),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
        .byte_D(byte_D), .byte_enable(byte_enable), .pixel_pronto(pixel_pronto),
        .x(x), .y(y), .ocupado(ocupado), .frame_pronto(frame_pronto), .erro_linha(erro_linha)
    );

    always #5 clock = ~clock;

    typedef struct { int x; int y; } pix_t;

    logic [7:0] exp_bytes[$];
    pix_t       exp_pix[$];
    bit         exp_frames[$];
    int         total = 0;
    int         bad = 0;
    bit         captura_esperada = 1'b0;
    bit         erro_esp;

    task automatic chk(input string nome, input longint act, input longint esp);
        total++;
        if (act != esp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, act, esp, $time);
        end
    endtask

    task automatic monitor();
        logic [7:0] b;
        pix_t       p;
        bit         e;
        forever begin
            @(negedge clock);
            if (byte_enable) begin
                if (exp_bytes.size() == 0) chk("byte_inesperado", byte_enable, 0);
                else begin
                    b = exp_bytes.pop_front();
                    chk("byte_D", byte_D, b);
                end
            end
            if (pixel_pronto) begin
                if (exp_pix.size() == 0) chk("pixel_inesperado", pixel_pronto, 0);
                else begin
                    p = exp_pix.pop_front();
                    chk("pixel_x", x, p.x);
                    chk("pixel_y", y, p.y);
                end
            end
            if (frame_pronto) begin
                if (exp_frames.size() == 0) chk("frame_inesperado", frame_pronto, 0);
                else begin
                    e = exp_frames.pop_front();
                    chk("erro_no_fim", erro_linha, e);
                    chk("ocupado_no_fim", ocupado, 0);
                end
            end
        end
    endtask

    // One PCLK period: signals change while PCLK is low, PCLK then rises.
    task automatic per(input logic [7:0] d, input logic href, input logic vs);
        cam_d = d; cam_href = href; cam_vsync = vs; cam_pclk = 1'b0;
        repeat (2) @(negedge clock);
        cam_pclk = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic modelo_pixel(input int ln, input int i, input logic [7:0] b0, input logic [7:0] b1);
        pix_t p;
        int   col;
        if (!captura_esperada) return;
        if (DEC && (((i % 2) != 0) || ((ln % 2) != 0))) return;
        col = (i > H - 1) ? H - 1 : i;
        p.x = DEC ? col / 2 : col;
        p.y = DEC ? ln / 2 : ln;
        exp_bytes.push_back(b0);
        exp_bytes.push_back(b1);
        exp_pix.push_back(p);
    endtask

    task automatic quadro(input bit cap, input int nl, input int len0, input bit fixo, output bit erro);
        logic [7:0] b0, b1;
        int         len;
        captura_esperada = cap;
        erro = (len0 != H) || (nl < V);
        if (cap) exp_frames.push_back(erro);
        repeat (3) per(8'h00, 1'b0, 1'b1);
        repeat (2) per(8'h00, 1'b0, 1'b0);
        for (int ln = 0; ln < nl; ln++) begin
            len = (ln == 0) ? len0 : H;
            for (int i = 0; i < len; i++) begin
                b0 = fixo ? 8'hAA : 8'($urandom);
                b1 = fixo ? 8'hCC : 8'($urandom);
                modelo_pixel(ln, i, b0, b1);
                per(b0, 1'b1, 1'b0);
                per(b1, 1'b1, 1'b0);
            end
            repeat (2) per(8'h00, 1'b0, 1'b0);
        end
        repeat (3) per(8'h00, 1'b0, 1'b1);
    endtask

    task automatic pulso_iniciar();
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        chk("ocupado_apos_iniciar", ocupado, 1);
        chk("erro_limpo_iniciar", erro_linha, 0);
    endtask

    task automatic chk_zeros(input string onde);
        chk({onde, "_byte_D"}, byte_D, 0);
        chk({onde, "_byte_enable"}, byte_enable, 0);
        chk({onde, "_pixel_pronto"}, pixel_pronto, 0);
        chk({onde, "_x"}, x, 0);
        chk({onde, "_y"}, y, 0);
        chk({onde, "_ocupado"}, ocupado, 0);
        chk({onde, "_frame_pronto"}, frame_pronto, 0);
        chk({onde, "_erro_linha"}, erro_linha, 0);
    endtask

    task automatic fim_quadro(input bit erro);
        chk("ocupado_pos_quadro", ocupado, 0);
        chk("erro_pos_quadro", erro_linha, erro);
    endtask

    initial begin
        reset_n = 1'b0; iniciar = 1'b0;
        cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = 8'h00;
        fork monitor(); join_none
        repeat (3) @(negedge clock);
        chk_zeros("reset");
        reset_n = 1'b1;

        // Fixed-pattern full frame
        pulso_iniciar();
        quadro(1'b1, V, H, 1'b1, erro_esp);
        fim_quadro(erro_esp);

        // Short first line
        pulso_iniciar();
        quadro(1'b1, V, H - 1, 1'b0, erro_esp);
        fim_quadro(erro_esp);

        // Premature VSYNC rise after line 0
        pulso_iniciar();
        quadro(1'b1, 1, H, 1'b0, erro_esp);
        fim_quadro(erro_esp);

        // Overlong first line: x saturates, extra pixel still strobed
        pulso_iniciar();
        quadro(1'b1, V, H + 1, 1'b0, erro_esp);
        fim_quadro(erro_esp);

        // Request lands mid-frame: that frame is skipped, the next is captured
        fork
            quadro(1'b0, V, H, 1'b0, erro_esp);
            begin
                repeat (28) @(negedge clock);
                iniciar = 1'b1;
                @(negedge clock);
                iniciar = 1'b0;
            end
        join
        chk("ocupado_espera_vsync", ocupado, 1);
        quadro(1'b1, V, H, 1'b0, erro_esp);
        fim_quadro(erro_esp);

        // Random data and line lengths
        for (int k = 0; k < 4; k++) begin
            pulso_iniciar();
            quadro(1'b1, V, $urandom_range(H + 1, H - 1), 1'b0, erro_esp);
            fim_quadro(erro_esp);
        end

        // Reset in the middle of a capture
        pulso_iniciar();
        fork
            quadro(1'b1, V, H, 1'b0, erro_esp);
            begin
                repeat (44) @(negedge clock);
                reset_n = 1'b0;
                #1;
                chk_zeros("reset_meio");
                captura_esperada = 1'b0;
                exp_bytes.delete();
                exp_pix.delete();
                exp_frames.delete();
            end
        join
        reset_n = 1'b1;
        pulso_iniciar();
        quadro(1'b1, V, H, 1'b1, erro_esp);
        fim_quadro(erro_esp);

        repeat (20) @(negedge clock);
        chk("bytes_pendentes", exp_bytes.size(), 0);
        chk("pixels_pendentes", exp_pix.size(), 0);
        chk("quadros_pendentes", exp_frames.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
